branch_ctrl: RTL

- Control-side counterpart to the program counter.
- Consumes the per-instruction branch/halt decode and ALU flags.
- Generates branch_taken, branch_skip, jump_en, jump_addr and halt toward the PC, and consumes the PC's registered read_jump feedback.
- Branches are two-word: an opcode word followed by a 9-bit absolute target word. This block tracks which word is being fetched, keeps halt sticky, checks protocol sync with the PC, and keeps branch statistics.

---
 rtl/branch_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch/halt sequencer paired with the program counter: tracks opcode vs. target
// word, holds halt, checks read_jump feedback, and keeps saturating branch statistics.
module branch_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              init_n,
  input  logic [ADDR_W-1:0] instr,
  input  logic              br_req,
  input  logic [1:0]        br_cond,
  input  logic              halt_req,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              read_jump,
  output logic              branch_taken,
  output logic              branch_skip,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              halt,
  output logic              sync_err,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_TARGET = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_cond_true;
  logic              w_br_eval;
  logic              w_sync_bad;
  logic              r_sync_err;
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_taken_count;

  always_comb begin
    w_cond_true = 1'b0;
    unique case (br_cond)
      2'b00:   w_cond_true = 1'b1;
      2'b01:   w_cond_true = flag_z;
      2'b10:   w_cond_true = ~flag_z;
      default: w_cond_true = flag_n;
    endcase
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are gated by init_n so they read as idle RUN while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_br_eval    = 1'b0;
    branch_taken = 1'b0;
    branch_skip  = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = '0;
    halt         = 1'b0;
    if (init_n) begin
      unique case (r_state)
        S_RUN: begin
          if (halt_req) begin
            halt         = 1'b1;
            w_next_state = S_HALTED;
          end else if (br_req) begin
            w_br_eval = 1'b1;
            if (w_cond_true) begin
              branch_taken = 1'b1;
              w_next_state = S_TARGET;
            end else begin
              branch_skip = 1'b1;
            end
          end
        end
        S_TARGET: begin
          jump_en      = 1'b1;
          jump_addr    = instr;
          w_next_state = S_RUN;
        end
        S_HALTED: begin
          halt = 1'b1;
        end
        default: begin
          w_next_state = S_RUN;
        end
      endcase
    end
  end

  assign w_sync_bad = ((r_state == S_TARGET) && !read_jump) ||
                      ((r_state == S_RUN) && read_jump);

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_sync_err <= 1'b0;
    end else if (w_sync_bad) begin
      r_sync_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (w_br_eval) begin
      if (r_br_count != '1) begin
        r_br_count <= r_br_count + CNT_W'(1);
      end
      if (w_cond_true && (r_taken_count != '1)) begin
        r_taken_count <= r_taken_count + CNT_W'(1);
      end
    end
  end

  assign sync_err    = r_sync_err;
  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;

endmodule
